store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter WIDTH, default 32: data width of stores and memory writes.
REQ-002 Parameter DEPTH, default 4: number of buffered stores; power of two.
REQ-003 Parameter MEM_AW, default 17: byte-address width of data memory.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 push_valid  input  1  write-through store offered by the cache (cache WE path).
REQ-007 push_addr  input  32  store byte address.
REQ-008 push_data  input  WIDTH  store data.
REQ-009 push_mode  input  3  store mode; 3'b011 or 3'b101 = byte store, all others = word store.
REQ-010 push_ready  output  1  buffer can accept a store this cycle.
REQ-011 mem_req  output  1  write request to data memory.
REQ-012 mem_addr  output  MEM_AW  head-entry address, push_addr[MEM_AW-1:0].
REQ-013 mem_data  output  WIDTH  head-entry data.
REQ-014 mem_byte  output  1  head entry is a byte store.
REQ-015 mem_ack  input  1  memory has committed the current request.
REQ-016 chk_addr  input  32  refill address probed by the cache on a miss.
REQ-017 chk_hit  output  1  a buffered store targets the same 8-byte line as chk_addr.
REQ-018 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-019 Storage is a circular FIFO; wr_ptr and rd_ptr wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-020 push_ready is 1 exactly when count < DEPTH; no pass-through when full, even if a pop occurs in the same cycle.
REQ-021 A push is accepted when push_valid && push_ready; entry {addr[MEM_AW-1:0], data, byte} is written at wr_ptr.
REQ-022 A push with push_addr == 32'h100 (trigger MMIO) is accepted and discarded; count and pointers unchanged.
REQ-023 Drain FSM states: IDLE, REQ, GAP.
REQ-024 IDLE -> REQ on the edge where count becomes or is nonzero; mem_req is 1 only in REQ.
REQ-025 In REQ, mem_addr/mem_data/mem_byte present the head entry and stay stable until mem_ack.
REQ-026 REQ with mem_ack -> GAP; the head entry is popped on that edge (rd_ptr+1, count-1).
REQ-027 GAP lasts exactly one cycle with mem_req 0, then -> REQ if count nonzero, else IDLE.
REQ-028 mem_ack outside REQ is ignored.
REQ-029 Latency: store pushed into an empty buffer in IDLE at edge t gives mem_req = 1 in the cycle after edge t.
REQ-030 Simultaneous push and pop: both take effect; count unchanged.
REQ-031 chk_hit is combinational: OR over valid entries of entry.addr[MEM_AW-1:3] == chk_addr[MEM_AW-1:3]; 0 when empty.
REQ-032 chk_hit includes the head entry in REQ until the edge it is popped.

Reset
REQ-033 On rst low, immediately and independent of clk: count 0, pointers 0, FSM IDLE, mem_req 0, push_ready 1, chk_hit 0.
REQ-034 Reset during REQ discards all entries; the in-flight request is abandoned and not retried.
REQ-035 Entry payload registers need not be reset; outputs derived from them are don't-care while mem_req is 0.

Structure
REQ-036 Entry typedef sb_entry_t and byte-mode constants 3'b011/3'b101 are declared in the shared cache_data_structs.sv package, not locally.
REQ-037 One sub-module, sb_fifo, holds storage, pointers, count and the chk_hit compare; FSM and output muxing stay in store_buffer.

Verification
REQ-038 Single store: push addr 0x10004, data 0xDEADBEEF, mode 3'b010 -> next cycle mem_req 1, mem_addr 0x10004, mem_byte 0; ack -> one GAP cycle, then IDLE, count 0.
REQ-039 Fill: 5 back-to-back pushes with mem_ack held 0 -> push_ready 0 after 4th, 5th not accepted, count 4; drain order matches push order.
REQ-040 Concurrent: count 2, push during ack cycle -> count stays 2; byte store mode 3'b101 drains with mem_byte 1.
REQ-041 Hazard: buffered store to 0x10008, chk_addr 0x1000C -> chk_hit 1; chk_addr 0x10010 -> chk_hit 0; after pop -> chk_hit 0.
REQ-042 MMIO: push addr 0x100 -> count stays 0, mem_req never asserts.
REQ-043 Reset mid-drain: count 3, REQ, assert rst low between edges -> mem_req 0 and count 0 without a clock edge; after release, no stale request.

Source files
------------

// File: rtl/cache_data_structs.sv
// Shared cache data-path types: store-buffer entry, drain FSM states and store-mode decode.
package cache_data_structs;

  localparam int unsigned SB_WIDTH  = 32;
  localparam int unsigned SB_MEM_AW = 17;
  localparam int unsigned SB_LINE_W = SB_MEM_AW - 3;

  localparam logic [2:0]  MODE_BYTE_A       = 3'b011;
  localparam logic [2:0]  MODE_BYTE_B       = 3'b101;
  localparam logic [31:0] MMIO_TRIGGER_ADDR = 32'h0000_0100;

  typedef struct packed {
    logic [SB_MEM_AW-1:0] addr;
    logic [SB_WIDTH-1:0]  data;
    logic                 is_byte;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_REQ  = 2'd1,
    SB_GAP  = 2'd2
  } sb_state_e;

  function automatic logic is_byte_mode(input logic [2:0] mode);
    return (mode == MODE_BYTE_A) || (mode == MODE_BYTE_B);
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store FIFO with occupancy count and an 8-byte-line hazard compare over valid entries.
module sb_fifo
  import cache_data_structs::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  sb_entry_t              entry_i,
  input  logic                   pop_i,
  input  logic [SB_LINE_W-1:0]   chk_line_i,
  output sb_entry_t              head_c,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_c,
  output logic                   chk_hit_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] slot_off_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is only observed through valid slots, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // A slot is valid when its distance from the read pointer is below the count.
  always_comb begin
    chk_hit_c  = 1'b0;
    slot_off_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_off_c = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(slot_off_c) < count_q) &&
          (mem_q[i].addr[SB_MEM_AW-1:3] == chk_line_i)) begin
        chk_hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write-through store buffer: queues cache stores and drains them to data memory with a REQ/GAP handshake.
module store_buffer
  import cache_data_structs::*;
#(
  parameter int unsigned WIDTH  = SB_WIDTH,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MEM_AW = SB_MEM_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [31:0]            push_addr,
  input  logic [WIDTH-1:0]       push_data,
  input  logic [2:0]             push_mode,
  output logic                   push_ready,
  output logic                   mem_req,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [WIDTH-1:0]       mem_data,
  output logic                   mem_byte,
  input  logic                   mem_ack,
  input  logic [31:0]            chk_addr,
  output logic                   chk_hit,
  output logic [$clog2(DEPTH):0] count
);

  sb_state_e            state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 push_en_c, pop_en_c, full_c, have_work_c;
  sb_entry_t            push_entry_c, head_c;
  logic [SB_LINE_W-1:0] chk_line_c;
  logic                 unused_chk_bits;

  // Stores to the MMIO trigger address are accepted but never buffered.
  assign push_ready = !full_c;
  assign push_en_c  = push_valid && !full_c && (push_addr != MMIO_TRIGGER_ADDR);

  always_comb begin
    push_entry_c.addr    = SB_MEM_AW'(push_addr[MEM_AW-1:0]);
    push_entry_c.data    = SB_WIDTH'(push_data);
    push_entry_c.is_byte = is_byte_mode(push_mode);
  end

  assign chk_line_c      = SB_LINE_W'(chk_addr[MEM_AW-1:3]);
  assign unused_chk_bits = ^{chk_addr[31:MEM_AW], chk_addr[2:0]};

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push_i     (push_en_c),
    .entry_i    (push_entry_c),
    .pop_i      (pop_en_c),
    .chk_line_i (chk_line_c),
    .head_c     (head_c),
    .count_o    (count),
    .full_c     (full_c),
    .chk_hit_c  (chk_hit)
  );

  // Work exists after this edge if entries remain or one is being pushed now.
  assign have_work_c = (count != '0) || push_en_c;

  always_comb begin
    state_d  = state_q;
    pop_en_c = 1'b0;
    case (state_q)
      SB_IDLE: if (have_work_c) state_d = SB_REQ;
      SB_REQ: begin
        if (mem_ack) begin
          pop_en_c = 1'b1;
          state_d  = SB_GAP;
        end
      end
      SB_GAP:  state_d = have_work_c ? SB_REQ : SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
    mem_req_d = (state_d == SB_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SB_IDLE;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = MEM_AW'(head_c.addr);
  assign mem_data = WIDTH'(head_c.data);
  assign mem_byte = head_c.is_byte;

endmodule
